// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial full subtractor, LSB first, start/busy/done handshake
// One full-subtractor cell plus a borrow flop processes one operand bit per clock.

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;
   logic             r_br;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;

   logic w_a0;
   logic w_b0;
   logic w_d;
   logic w_br_next;

   assign w_a0      = r_a[0];
   assign w_b0      = r_b[0];
   assign w_d       = w_a0 ^ w_b0 ^ r_br;
   assign w_br_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_br);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_br    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_br    <= Bin;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_res <= {w_d, r_res[WIDTH-1:1]};
               r_br  <= w_br_next;
               r_cnt <= r_cnt + 1'b1;
               // Final bit: publish the completed word straight from the cell output.
               if (r_cnt == LAST_BIT) begin
                  r_diff  <= {w_d, r_res[WIDTH-1:1]};
                  r_bout  <= w_br_next;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign Diff = r_diff;
   assign Bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
// Directed vector table, hand-written abort/ignore sequences, and a randomized back-to-back sweep.

module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bin;
   logic         busy;
   logic         done;
   logic [W-1:0] Diff;
   logic         Bout;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .A    (A),
      .B    (B),
      .Bin  (Bin),
      .busy (busy),
      .done (done),
      .Diff (Diff),
      .Bout (Bout)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bin;
      logic [W-1:0] exp_diff;
      logic         exp_bout;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Plain integer arithmetic: difference modulo 2^W and borrow when it goes negative.
   function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                   output logic [W-1:0] d, output logic bo);
      int v;
      v  = int'(a) - int'(b) - int'(bin);
      d  = v[W-1:0];
      bo = (v < 0);
   endfunction

   // One full op: busy count, held previous result, single done pulse with the right value.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic [W-1:0] exp_d, input logic exp_bo, input string tag);
      int nbusy;
      int ndone;
      int nchg;
      logic [W-1:0] prev;
      nbusy = 0;
      ndone = 0;
      nchg  = 0;
      prev  = Diff;
      start = 1'b1; A = a; B = b; Bin = bin;
      @(negedge clk);
      start = 1'b0; A = ~a; B = ~b; Bin = ~bin;
      for (int k = 0; k < W; k++) begin
         if (busy) nbusy++;
         if (done) ndone++;
         if (Diff !== prev) nchg++;
         if (k != W - 1) @(negedge clk);
      end
      @(negedge clk);
      check({tag, "_busy_cycles"}, nbusy, W);
      check({tag, "_hold_during_run"}, nchg, 0);
      check({tag, "_no_early_done"}, ndone, 0);
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_busy_at_done"}, busy, 1'b0);
      check({tag, "_diff"}, Diff, exp_d);
      check({tag, "_bout"}, Bout, exp_bo);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, done, 1'b0);
   endtask

   initial begin
      int nbusy;
      int ndone;
      int issued;
      int got;
      int last_done;
      logic [W-1:0] qa[$];
      logic [W-1:0] qb[$];
      logic         qbin[$];
      logic [W-1:0] ed;
      logic         eb;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbin;

      vecs[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0};
      vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
      vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
      vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[5] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
      vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0};

      rst = 1'b1; start = 1'b1; A = 8'h11; B = 8'h22; Bin = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_diff", Diff, 8'h00);
      check("reset_bout", Bout, 1'b0);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_bout,
                $sformatf("vec%0d", i));

      // Second start during RUN must be ignored.
      nbusy = 0; ndone = 0;
      start = 1'b1; A = 8'h50; B = 8'h20; Bin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= W + 4; k++) begin
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            check("ignore_diff", Diff, 8'h30);
            check("ignore_bout", Bout, 1'b0);
         end
         start = (k == 3);
         A = (k == 3) ? 8'h01 : 8'h00;
         B = (k == 3) ? 8'h02 : 8'h00;
         @(negedge clk);
      end
      start = 1'b0;
      check("ignore_busy_cycles", nbusy, W);
      check("ignore_done_pulses", ndone, 1);

      // Reset during RUN aborts the op with no done pulse.
      ndone = 0;
      start = 1'b1; A = 8'h50; B = 8'h20; Bin = 1'b0;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", busy, 1'b0);
      check("abort_diff", Diff, 8'h00);
      check("abort_bout", Bout, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < W + 4; k++) begin
         if (done || busy) ndone++;
         @(negedge clk);
      end
      check("abort_no_done", ndone, 0);
      run_op(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, "after_abort");

      // Back-to-back sweep with start held high; operands scrambled while busy.
      issued = 0; got = 0; last_done = -1;
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      A = ra; B = rb; Bin = rbin; start = 1'b1;
      qa.push_back(ra); qb.push_back(rb); qbin.push_back(rbin);
      issued = 1;
      for (int cyc = 0; cyc < 256 * (W + 2) + 40 && got < 256; cyc++) begin
         @(negedge clk);
         if (busy) begin
            A = 8'($urandom); B = 8'($urandom); Bin = 1'($urandom);
         end
         if (done) begin
            ref_sub(qa.pop_front(), qb.pop_front(), qbin.pop_front(), ed, eb);
            check($sformatf("sweep%0d_diff", got), Diff, ed);
            check($sformatf("sweep%0d_bout", got), Bout, eb);
            if (last_done >= 0) check($sformatf("sweep%0d_spacing", got), cyc - last_done, W + 2);
            last_done = cyc;
            got++;
            if (issued < 256) begin
               ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
               A = ra; B = rb; Bin = rbin;
               qa.push_back(ra); qb.push_back(rb); qbin.push_back(rbin);
               issued++;
            end else begin
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      check("sweep_completed_ops", got, 256);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
